// File: rtl/lsb_mem_port_if.sv
// LSB<->memory port bundle: request handshake from the LSB, memory issue/completion
// lines and the load-result return path. master = the lsb_mem_port side.
`ifndef LSB_WIDTH
`define LSB_WIDTH 4
`endif
`ifndef VAL_WIDTH
`define VAL_WIDTH 32
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

interface lsb_mem_port_if;
  logic                   req_valid;
  logic                   req_ready;
  logic                   req_is_store;
  logic [`LSB_WIDTH-1:0]  req_id;
  logic [`ADDR_WIDTH-1:0] req_addr;
  logic [`VAL_WIDTH-1:0]  req_val;

  logic                   lsb2mem_load_req;
  logic [`ADDR_WIDTH-1:0] lsb2mem_load_addr;
  logic [`LSB_WIDTH-1:0]  lsb2mem_load_id;
  logic                   lsb2mem_store_req;
  logic [`ADDR_WIDTH-1:0] lsb2mem_store_addr;
  logic [`VAL_WIDTH-1:0]  lsb2mem_store_val;

  logic                   mem2lsb_load_en;
  logic [`LSB_WIDTH-1:0]  mem2lsb_load_id;
  logic [`VAL_WIDTH-1:0]  mem2lsb_load_val;
  logic                   mem2lsb_store_en;

  logic                   ld_done_valid;
  logic [`LSB_WIDTH-1:0]  ld_done_id;
  logic [`VAL_WIDTH-1:0]  ld_done_val;

  modport master (
    input  req_valid, req_is_store, req_id, req_addr, req_val,
    output req_ready,
    output lsb2mem_load_req, lsb2mem_load_addr, lsb2mem_load_id,
    output lsb2mem_store_req, lsb2mem_store_addr, lsb2mem_store_val,
    input  mem2lsb_load_en, mem2lsb_load_id, mem2lsb_load_val, mem2lsb_store_en,
    output ld_done_valid, ld_done_id, ld_done_val
  );

  modport slave (
    output req_valid, req_is_store, req_id, req_addr, req_val,
    input  req_ready,
    input  lsb2mem_load_req, lsb2mem_load_addr, lsb2mem_load_id,
    input  lsb2mem_store_req, lsb2mem_store_addr, lsb2mem_store_val,
    output mem2lsb_load_en, mem2lsb_load_id, mem2lsb_load_val, mem2lsb_store_en,
    input  ld_done_valid, ld_done_id, ld_done_val
  );
endinterface

// File: rtl/lsb_mem_port.sv
// LSB-side memory initiator: FIFO of load/store requests, one access in flight at a time.
// Define LSB_MEMPORT_PERF_EN to add the perf_ld_cnt/perf_st_cnt/perf_stall_cnt counters.
`ifndef LSB_WIDTH
`define LSB_WIDTH 4
`endif
`ifndef VAL_WIDTH
`define VAL_WIDTH 32
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

module lsb_mem_port #(
  parameter int QDEPTH_LOG = 2
) (
  input  logic           clk,
  input  logic           rst_in,
  input  logic           rdy_in,
  input  logic           flush_in,
  lsb_mem_port_if.master bus
`ifdef LSB_MEMPORT_PERF_EN
  ,
  output logic [31:0]    perf_ld_cnt,
  output logic [31:0]    perf_st_cnt,
  output logic [31:0]    perf_stall_cnt
`endif
);
  localparam int QDEPTH = 1 << QDEPTH_LOG;
  localparam int ID_W   = `LSB_WIDTH;
  localparam int DATA_W = `VAL_WIDTH;
  localparam int ADDR_W = `ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT_LD = 2'd1, WAIT_ST = 2'd2} state_t;
  state_t state, state_n;

  logic              q_store   [QDEPTH];
  logic [ID_W-1:0]   q_id      [QDEPTH];
  logic [ADDR_W-1:0] q_addr    [QDEPTH];
  logic [DATA_W-1:0] q_val     [QDEPTH];
  logic              q_store_n [QDEPTH];
  logic [ID_W-1:0]   q_id_n    [QDEPTH];
  logic [ADDR_W-1:0] q_addr_n  [QDEPTH];
  logic [DATA_W-1:0] q_val_n   [QDEPTH];

  logic [QDEPTH_LOG-1:0] head, tail, head_n, tail_n, idx;
  logic [QDEPTH_LOG:0]   cnt, cnt_n, keep;

  logic              ready_en;
  logic              act, flush_act, enq, issue, head_store;
  logic [ID_W-1:0]   iss_id;
  logic [ADDR_W-1:0] iss_addr;
  logic [DATA_W-1:0] iss_val;

  logic              pend_ld, pend_st;
  logic [ID_W-1:0]   pend_id;
  logic [DATA_W-1:0] pend_val;
  logic              ld_hit, st_hit, ld_accept, st_accept;
  logic [ID_W-1:0]   hit_id;
  logic [DATA_W-1:0] hit_val;

  logic              done_vld_p1;
  logic [ID_W-1:0]   done_id_p1;
  logic [DATA_W-1:0] done_val_p1;

  // Nothing moves while rdy_in is low; flush beats both issue and enqueue.
  assign act        = rst_in && rdy_in;
  assign flush_act  = act && flush_in;
  assign bus.req_ready = rst_in && ready_en && (cnt != (QDEPTH_LOG+1)'(QDEPTH));
  assign enq        = act && bus.req_valid && bus.req_ready;
  assign head_store = q_store[head];
  assign issue      = act && !flush_in && (state == IDLE) && (cnt != '0);

  // Completions seen while frozen are replayed from the pending register.
  assign ld_hit    = bus.mem2lsb_load_en || pend_ld;
  assign hit_id    = bus.mem2lsb_load_en ? bus.mem2lsb_load_id  : pend_id;
  assign hit_val   = bus.mem2lsb_load_en ? bus.mem2lsb_load_val : pend_val;
  assign st_hit    = bus.mem2lsb_store_en || pend_st;
  assign ld_accept = act && !flush_in && (state == WAIT_LD) && ld_hit && (hit_id == iss_id);
  assign st_accept = act && (state == WAIT_ST) && st_hit;

  always_comb begin
    q_store_n = q_store;
    q_id_n    = q_id;
    q_addr_n  = q_addr;
    q_val_n   = q_val;
    head_n    = head;
    tail_n    = tail;
    cnt_n     = cnt;
    keep      = '0;
    idx       = '0;
    if (flush_act) begin
      // Compact surviving stores to slot 0 upward, preserving their order.
      for (int i = 0; i < QDEPTH; i++) begin
        idx = head + QDEPTH_LOG'(i);
        if (((QDEPTH_LOG+1)'(i) < cnt) && q_store[idx]) begin
          q_store_n[keep[QDEPTH_LOG-1:0]] = 1'b1;
          q_id_n[keep[QDEPTH_LOG-1:0]]    = q_id[idx];
          q_addr_n[keep[QDEPTH_LOG-1:0]]  = q_addr[idx];
          q_val_n[keep[QDEPTH_LOG-1:0]]   = q_val[idx];
          keep = keep + 1'b1;
        end
      end
      head_n = '0;
      tail_n = keep[QDEPTH_LOG-1:0];
      cnt_n  = keep;
      if (enq && bus.req_is_store) begin
        q_store_n[tail_n] = 1'b1;
        q_id_n[tail_n]    = bus.req_id;
        q_addr_n[tail_n]  = bus.req_addr;
        q_val_n[tail_n]   = bus.req_val;
        tail_n = tail_n + 1'b1;
        cnt_n  = cnt_n + 1'b1;
      end
    end else begin
      if (issue) begin
        head_n = head + 1'b1;
        cnt_n  = cnt_n - 1'b1;
      end
      if (enq) begin
        q_store_n[tail] = bus.req_is_store;
        q_id_n[tail]    = bus.req_id;
        q_addr_n[tail]  = bus.req_addr;
        q_val_n[tail]   = bus.req_val;
        tail_n = tail + 1'b1;
        cnt_n  = cnt_n + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_in) state <= IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (act) begin
      case (state)
        IDLE:    if (issue) state_n = head_store ? WAIT_ST : WAIT_LD;
        WAIT_LD: if (flush_in || ld_accept) state_n = IDLE;
        WAIT_ST: if (st_accept) state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  // Request lines show the head entry on the issue cycle, then the latched copy.
  always_comb begin
    bus.lsb2mem_load_req   = 1'b0;
    bus.lsb2mem_load_addr  = '0;
    bus.lsb2mem_load_id    = '0;
    bus.lsb2mem_store_req  = 1'b0;
    bus.lsb2mem_store_addr = '0;
    bus.lsb2mem_store_val  = '0;
    case (state)
      IDLE: begin
        if (issue && head_store) begin
          bus.lsb2mem_store_req  = 1'b1;
          bus.lsb2mem_store_addr = q_addr[head];
          bus.lsb2mem_store_val  = q_val[head];
        end else if (issue) begin
          bus.lsb2mem_load_req  = 1'b1;
          bus.lsb2mem_load_addr = q_addr[head];
          bus.lsb2mem_load_id   = q_id[head];
        end
      end
      WAIT_LD: begin
        bus.lsb2mem_load_addr = iss_addr;
        bus.lsb2mem_load_id   = iss_id;
      end
      WAIT_ST: begin
        bus.lsb2mem_store_addr = iss_addr;
        bus.lsb2mem_store_val  = iss_val;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_in) begin
      head        <= '0;
      tail        <= '0;
      cnt         <= '0;
      ready_en    <= 1'b0;
      pend_ld     <= 1'b0;
      pend_st     <= 1'b0;
      done_vld_p1 <= 1'b0;
      done_id_p1  <= '0;
      done_val_p1 <= '0;
    end else begin
      ready_en <= 1'b1;
      if (rdy_in) begin
        head        <= head_n;
        tail        <= tail_n;
        cnt         <= cnt_n;
        pend_ld     <= 1'b0;
        pend_st     <= 1'b0;
        done_vld_p1 <= ld_accept;
        if (ld_accept) begin
          done_id_p1  <= hit_id;
          done_val_p1 <= hit_val;
        end
      end else begin
        if (bus.mem2lsb_load_en)  pend_ld <= 1'b1;
        if (bus.mem2lsb_store_en) pend_st <= 1'b1;
        done_vld_p1 <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rdy_in) begin
      q_store <= q_store_n;
      q_id    <= q_id_n;
      q_addr  <= q_addr_n;
      q_val   <= q_val_n;
      if (issue) begin
        iss_id   <= q_id[head];
        iss_addr <= q_addr[head];
        iss_val  <= q_val[head];
      end
    end else if (bus.mem2lsb_load_en) begin
      pend_id  <= bus.mem2lsb_load_id;
      pend_val <= bus.mem2lsb_load_val;
    end
  end

  // ---- stage p1: load result back to the LSB
  assign bus.ld_done_valid = done_vld_p1;
  assign bus.ld_done_id    = done_id_p1;
  assign bus.ld_done_val   = done_val_p1;

`ifdef LSB_MEMPORT_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst_in) begin
      perf_ld_cnt    <= '0;
      perf_st_cnt    <= '0;
      perf_stall_cnt <= '0;
    end else if (rdy_in) begin
      if (ld_accept) perf_ld_cnt <= perf_ld_cnt + 32'd1;
      if (st_accept) perf_st_cnt <= perf_st_cnt + 32'd1;
      if (bus.req_valid && !bus.req_ready) perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_lsb_mem_port.sv
// Randomized bench for lsb_mem_port: a transaction-level model (request queue, one
// outstanding access, pending completion while frozen) predicts every output.
`ifndef LSB_WIDTH
`define LSB_WIDTH 4
`endif
`ifndef VAL_WIDTH
`define VAL_WIDTH 32
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

module tb_lsb_mem_port;
  localparam int IW   = `LSB_WIDTH;
  localparam int AW   = `ADDR_WIDTH;
  localparam int VW   = `VAL_WIDTH;
  localparam int NCYC = 6000;

  logic clk = 1'b0;
  logic rst_in, rdy_in, flush_in;
  lsb_mem_port_if bus();
`ifdef LSB_MEMPORT_PERF_EN
  logic [31:0] perf_ld_cnt, perf_st_cnt, perf_stall_cnt;
`endif

  lsb_mem_port dut (
    .clk      (clk),
    .rst_in   (rst_in),
    .rdy_in   (rdy_in),
    .flush_in (flush_in),
    .bus      (bus)
`ifdef LSB_MEMPORT_PERF_EN
    ,
    .perf_ld_cnt    (perf_ld_cnt),
    .perf_st_cnt    (perf_st_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            st;
    logic [IW-1:0] id;
    logic [AW-1:0] addr;
    logic [VW-1:0] val;
  } req_t;

  typedef struct {
    int            due;
    bit            st;
    bit            stale;
    logic [IW-1:0] id;
    logic [VW-1:0] val;
  } ev_t;

  req_t fifo[$];
  req_t tmpq[$];
  ev_t  evq[$];
  req_t cur;
  int   ost;               // 0 none, 1 load outstanding, 2 store outstanding
  bit   pend_ld, pend_st, exp_done, ready_ok, rst_prev, nd;
  bit   exp_ready, exp_issue, lh, sh;
  logic [IW-1:0] pend_id, done_id, lh_id, next_id;
  logic [VW-1:0] pend_val, done_val, lh_val;
  int   rst_left, next_rst_at, phase, pick;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task model_reset();
    fifo.delete();
    evq.delete();
    ost      = 0;
    pend_ld  = 0;
    pend_st  = 0;
    exp_done = 0;
    ready_ok = 0;
  endtask

  task drive(input int cyc);
    bus.mem2lsb_load_en  = 1'b0;
    bus.mem2lsb_store_en = 1'b0;
    bus.mem2lsb_load_id  = IW'($urandom);
    bus.mem2lsb_load_val = VW'($urandom);
    if (rst_left == 0 && cyc >= next_rst_at && (ost == 2 || cyc >= next_rst_at + 300)) begin
      rst_left    = 3;
      next_rst_at = next_rst_at + 2000;
    end
    if (rst_left > 0) begin
      rst_left--;
      rst_in        = 1'b0;
      rdy_in        = 1'b1;
      flush_in      = 1'b0;
      bus.req_valid = 1'b0;
      return;
    end
    rst_in   = 1'b1;
    phase    = (cyc / 400) % 4;
    rdy_in   = ($urandom_range(0, 99) < (phase == 2 ? 60 : 92));
    flush_in = ($urandom_range(0, 99) < (phase == 3 ? 10 : 3));
    bus.req_valid    = ($urandom_range(0, 99) < 60);
    bus.req_is_store = 1'($urandom_range(0, 1));
    bus.req_addr     = AW'($urandom);
    bus.req_val      = VW'($urandom);
    bus.req_id       = next_id;
    if (!bus.req_is_store) next_id = next_id + 1'b1;

    // Present at most one load completion per freeze window.
    if (!pend_ld) begin
      pick = -1;
      foreach (evq[i])
        if (!evq[i].st && evq[i].due <= cyc && (pick < 0 || evq[i].due < evq[pick].due)) pick = i;
      if (pick >= 0) begin
        if (!(evq[pick].stale && ost == 1 && evq[pick].id == cur.id)) begin
          bus.mem2lsb_load_en  = 1'b1;
          bus.mem2lsb_load_id  = evq[pick].id;
          bus.mem2lsb_load_val = evq[pick].val;
        end
        evq.delete(pick);
      end else if ($urandom_range(0, 19) == 0) begin
        bus.mem2lsb_load_en = 1'b1;
        if (ost == 1) bus.mem2lsb_load_id = cur.id ^ IW'($urandom_range(1, (1 << IW) - 1));
      end
    end
    foreach (evq[i])
      if (evq[i].st && evq[i].due <= cyc) begin
        bus.mem2lsb_store_en = 1'b1;
        evq.delete(i);
        break;
      end
  endtask

  task evaluate(input int cyc);
    ev_t ev;
    req_t r;
    if (!rst_in) begin
      if (rst_prev) begin
        check("rst_ready",      64'(bus.req_ready), 64'(0));
        check("rst_load_req",   64'(bus.lsb2mem_load_req), 64'(0));
        check("rst_store_req",  64'(bus.lsb2mem_store_req), 64'(0));
        check("rst_load_addr",  64'(bus.lsb2mem_load_addr), 64'(0));
        check("rst_store_addr", 64'(bus.lsb2mem_store_addr), 64'(0));
        check("rst_store_val",  64'(bus.lsb2mem_store_val), 64'(0));
        check("rst_done_valid", 64'(bus.ld_done_valid), 64'(0));
        check("rst_done_val",   64'(bus.ld_done_val), 64'(0));
      end
      model_reset();
      rst_prev = 1;
      return;
    end
    rst_prev  = 0;
    exp_ready = ready_ok && (fifo.size() < 4);
    check("req_ready", 64'(bus.req_ready), 64'(exp_ready));
    exp_issue = rdy_in && !flush_in && ost == 0 && fifo.size() > 0;
    check("issue", 64'(bus.lsb2mem_load_req | bus.lsb2mem_store_req), 64'(exp_issue));
    if (exp_issue) begin
      check("issue_kind", 64'(bus.lsb2mem_store_req), 64'(fifo[0].st));
      if (fifo[0].st) begin
        check("st_addr", 64'(bus.lsb2mem_store_addr), 64'(fifo[0].addr));
        check("st_val",  64'(bus.lsb2mem_store_val), 64'(fifo[0].val));
      end else begin
        check("ld_addr", 64'(bus.lsb2mem_load_addr), 64'(fifo[0].addr));
        check("ld_id",   64'(bus.lsb2mem_load_id), 64'(fifo[0].id));
      end
    end
    if (ost == 1) begin
      check("ld_addr_hold", 64'(bus.lsb2mem_load_addr), 64'(cur.addr));
      check("ld_id_hold",   64'(bus.lsb2mem_load_id), 64'(cur.id));
    end
    if (ost == 2) begin
      check("st_addr_hold", 64'(bus.lsb2mem_store_addr), 64'(cur.addr));
      check("st_val_hold",  64'(bus.lsb2mem_store_val), 64'(cur.val));
    end
    check("done_valid", 64'(bus.ld_done_valid), 64'(exp_done));
    if (exp_done) begin
      check("done_id",  64'(bus.ld_done_id), 64'(done_id));
      check("done_val", 64'(bus.ld_done_val), 64'(done_val));
    end

    nd = 0;
    if (rdy_in) begin
      lh     = bus.mem2lsb_load_en || pend_ld;
      lh_id  = bus.mem2lsb_load_en ? bus.mem2lsb_load_id : pend_id;
      lh_val = bus.mem2lsb_load_en ? bus.mem2lsb_load_val : pend_val;
      sh     = bus.mem2lsb_store_en || pend_st;
      if (ost == 1) begin
        if (flush_in) ost = 0;
        else if (lh && lh_id == cur.id) begin
          nd       = 1;
          done_id  = cur.id;
          done_val = lh_val;
          ost      = 0;
        end
      end else if (ost == 2 && sh) ost = 0;
      pend_ld = 0;
      pend_st = 0;
      r.st   = bus.req_is_store;
      r.id   = bus.req_id;
      r.addr = bus.req_addr;
      r.val  = bus.req_val;
      if (flush_in) begin
        tmpq.delete();
        foreach (fifo[i]) if (fifo[i].st) tmpq.push_back(fifo[i]);
        fifo = tmpq;
        foreach (evq[i]) if (!evq[i].st) evq[i].stale = 1;
        if (bus.req_valid && exp_ready && r.st) fifo.push_back(r);
      end else begin
        if (exp_issue) begin
          cur      = fifo.pop_front();
          ost      = cur.st ? 2 : 1;
          ev.due   = cyc + (phase == 1 ? $urandom_range(6, 12) : $urandom_range(1, 4));
          ev.st    = cur.st;
          ev.stale = 0;
          ev.id    = cur.id;
          ev.val   = VW'($urandom);
          evq.push_back(ev);
        end
        if (bus.req_valid && exp_ready) fifo.push_back(r);
      end
    end else begin
      if (bus.mem2lsb_load_en) begin
        pend_ld  = 1;
        pend_id  = bus.mem2lsb_load_id;
        pend_val = bus.mem2lsb_load_val;
      end
      if (bus.mem2lsb_store_en) pend_st = 1;
    end
    exp_done = nd;
    ready_ok = 1;
  endtask

  initial begin
    rst_in = 1'b0;
    rdy_in = 1'b1;
    flush_in = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_is_store = 1'b0;
    bus.req_id = '0;
    bus.req_addr = '0;
    bus.req_val = '0;
    bus.mem2lsb_load_en = 1'b0;
    bus.mem2lsb_load_id = '0;
    bus.mem2lsb_load_val = '0;
    bus.mem2lsb_store_en = 1'b0;
    next_id = '0;
    rst_prev = 0;
    rst_left = 3;
    next_rst_at = 1500;
    phase = 0;
    model_reset();
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge clk);
      #1;
      drive(cyc);
      @(negedge clk);
      evaluate(cyc);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
